// File: rtl/adder_seq_arbiter.sv
// Two-requester round-robin front end for one shared 4-bit ripple adder slice run nibble-serially.
// Optional signed-overflow output rsp_ovf when ADDSEQ_OVF_EN is defined.
module adder_seq_arbiter #(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_cin,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_id,
`ifdef ADDSEQ_OVF_EN
    output logic                   rsp_ovf,
`endif
    output logic                   busy
);

    localparam int WIDTH = 4 * NIBBLES;
    localparam int IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              id_q, id_d;
    logic              last_q, last_d;
`ifdef ADDSEQ_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic              grant0, grant1;
    logic [3:0]        nib_a, nib_b, slice_sum;
    logic              slice_co;

    // On a tie the requester that did not win last time gets the slot.
    assign grant0     = req0_valid & (~req1_valid | last_q);
    assign grant1     = req1_valid & (~req0_valid | ~last_q);
    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;

    assign nib_a = a_q[4*idx_q +: 4];
    assign nib_b = b_q[4*idx_q +: 4];

    always_comb begin : slice
        logic c;
        c         = carry_q;
        slice_sum = '0;
        for (int i = 0; i < 4; i++) begin
            slice_sum[i] = nib_a[i] ^ nib_b[i] ^ c;
            c = (nib_a[i] & nib_b[i]) | (c & (nib_a[i] ^ nib_b[i]));
        end
        slice_co = c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        id_d    = id_q;
        last_d  = last_q;
`ifdef ADDSEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0_ready | req1_ready) begin
                    a_d     = req1_ready ? req1_a : req0_a;
                    b_d     = req1_ready ? req1_b : req0_b;
                    carry_d = req1_ready ? req1_cin : req0_cin;
                    id_d    = req1_ready;
                    last_d  = req1_ready;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = slice_sum;
                carry_d = slice_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NIBBLES - 1)) begin
                    cout_d  = slice_co;
`ifdef ADDSEQ_OVF_EN
                    ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[3] ^ slice_co;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
`ifdef ADDSEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            last_q  <= last_d;
`ifdef ADDSEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;
`ifdef ADDSEQ_OVF_EN
    assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq_arbiter.sv
// Directed, table-driven bench for adder_seq_arbiter (NIBBLES=2, 8-bit operands).
// Covers arbitration, carry chain, backpressure, mid-run reset and the optional overflow flag.
module tb_adder_seq_arbiter;

    localparam int NIB = 2;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
    logic [W-1:0] rsp_sum;
`ifdef ADDSEQ_OVF_EN
    logic         rsp_ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_seq_arbiter #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
`ifdef ADDSEQ_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .busy       (busy)
    );

    typedef struct {
        logic         v0;
        logic         v1;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic         c0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic         c1;
        logic         exp_id;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        int           hold;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic txn(input vec_t v);
        int cyc;
        logic [W-1:0] s;
        logic c, id;
        @(negedge clk);
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_cin = v.c0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_cin = v.c1;
        #1;
        check("ready0", req0_ready, v.exp_id == 1'b0);
        check("ready1", req1_ready, v.exp_id == 1'b1);
        check("one_ready", req0_ready & req1_ready, 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~v.a0; req0_b = 8'h5A; req0_cin = ~v.c0;
        req1_a = ~v.a1; req1_b = 8'hA5; req1_cin = ~v.c1;
        check("busy_run", busy, 1);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, NIB);
        check("sum", rsp_sum, v.exp_sum);
        check("cout", rsp_cout, v.exp_cout);
        check("id", rsp_id, v.exp_id);
`ifdef ADDSEQ_OVF_EN
        check("ovf", rsp_ovf, v.exp_ovf);
`endif
        s = rsp_sum; c = rsp_cout; id = rsp_id;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            check("bp_ready", {req0_ready, req1_ready}, 0);
            @(posedge clk);
            #1;
            check("bp_valid", rsp_valid, 1);
            check("bp_stable", {rsp_sum, rsp_cout, rsp_id}, {s, c, id});
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("valid_drop", rsp_valid, 0);
        check("busy_idle", busy, 0);
    endtask

    function automatic vec_t mk(input logic v0, input logic v1,
                                input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                                input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                                input logic id, input logic [W-1:0] sum, input logic co,
                                input logic ovf, input int hold);
        vec_t v;
        v.v0 = v0; v.v1 = v1;
        v.a0 = a0; v.b0 = b0; v.c0 = c0;
        v.a1 = a1; v.b1 = b1; v.c1 = c1;
        v.exp_id = id; v.exp_sum = sum; v.exp_cout = co;
        v.exp_ovf = ovf; v.hold = hold;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        rsp_ready = 1'b0;

        // contention from reset: req0 wins first, then alternate
        vecs.push_back(mk(1, 1, 8'h11, 8'h22, 0, 8'h40, 8'h05, 0, 0, 8'h33, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'h11, 8'h22, 0, 8'h40, 8'h05, 0, 1, 8'h45, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'h11, 8'h22, 1, 8'h40, 8'h05, 1, 0, 8'h34, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'h11, 8'h22, 1, 8'h40, 8'h05, 1, 1, 8'h46, 0, 0, 0));
        // single requester cases
        vecs.push_back(mk(1, 0, 8'h3C, 8'h45, 0, 8'h00, 8'h00, 0, 0, 8'h81, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h00, 0, 8'hFF, 8'h00, 1, 1, 8'h00, 1, 0, 0));
        vecs.push_back(mk(1, 0, 8'h0F, 8'h01, 0, 8'h00, 8'h00, 0, 0, 8'h10, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h00, 0, 8'hA5, 8'h5A, 1, 1, 8'h00, 1, 0, 0));
        vecs.push_back(mk(1, 0, 8'h7F, 8'h01, 0, 8'h00, 8'h00, 0, 0, 8'h80, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h00, 0, 8'h80, 8'h80, 0, 1, 8'h00, 1, 1, 0));
        // backpressure: 5 cycles with rsp_ready low
        vecs.push_back(mk(1, 0, 8'h3C, 8'h45, 0, 8'h00, 8'h00, 0, 0, 8'h81, 0, 1, 5));

        #3;
        check("rst_valid", rsp_valid, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_cout", rsp_cout, 0);
        check("rst_id", rsp_id, 0);
        check("rst_busy", busy, 0);
`ifdef ADDSEQ_OVF_EN
        check("rst_ovf", rsp_ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {req0_ready, req1_ready}, 0);

        foreach (vecs[i]) txn(vecs[i]);

        // reset after the first nibble of a req1 transaction
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'h3C; req1_b = 8'h45; req1_cin = 1'b0;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_sum", rsp_sum, 0);
        check("mid_rst_cout", rsp_cout, 0);
        check("mid_rst_id", rsp_id, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_no_done", {rsp_valid, busy}, 0);
        txn(mk(1, 0, 8'h12, 8'h34, 0, 8'h00, 8'h00, 0, 0, 8'h46, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
